udp_tx_arb: RTL and testbench

//  Round-robin packet arbiter sharing the single 8-bit UDP transmit stream (toward udp_send/IP layer)

---
 rtl/udp_tx_arb.sv | 152 +++++++++++++++
 tb/tb_udp_tx_arb.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arb.sv
// udp_tx_arb: round-robin whole-packet arbiter onto the shared 8-bit UDP transmit stream,
// with a stall watchdog that force-closes a hung packet so downstream never locks.
module udp_tx_arb #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [8*NUM_REQ-1:0]  req_tdata_in,
    input  logic [NUM_REQ-1:0]    req_tvalid_in,
    input  logic [NUM_REQ-1:0]    req_tlast_in,
    output logic [NUM_REQ-1:0]    req_tready_out,
    input  logic [16*NUM_REQ-1:0] req_dest_port_in,
    input  logic [16*NUM_REQ-1:0] req_length_in,
    output logic [7:0]            udp_tdata_out,
    output logic                  udp_tvalid_out,
    output logic                  udp_tlast_out,
    input  logic                  udp_tready_in,
    output logic [15:0]           udp_dest_port_out,
    output logic [15:0]           udp_length_out,
    output logic [NUM_REQ-1:0]    grant_out,
    output logic                  busy_out,
    output logic                  len_err_out,
    output logic                  timeout_err_out
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, XFER, ABORT} state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IW-1:0]      gidx_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [15:0]        byte_cnt_q;
    logic [SW-1:0]      stall_cnt_q;
    logic [15:0]        port_q;
    logic [15:0]        len_q;
    logic               len_err_q;
    logic               timeout_err_q;

    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      cand_idx;
    logic               win_found;
    logic               beat;
    logic [16:0]        cnt_inc;

    // Search starts just past the previous winner, so the winner drops to lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!win_found && req_tvalid_in[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        udp_tdata_out  = '0;
        udp_tvalid_out = 1'b0;
        udp_tlast_out  = 1'b0;
        req_tready_out = '0;
        case (state_q)
            XFER: begin
                udp_tdata_out          = req_tdata_in[8*32'(gidx_q) +: 8];
                udp_tvalid_out         = req_tvalid_in[gidx_q];
                udp_tlast_out          = req_tlast_in[gidx_q];
                req_tready_out[gidx_q] = udp_tready_in;
            end
            ABORT: begin
                udp_tvalid_out = 1'b1;
                udp_tlast_out  = 1'b1;
            end
            default: ;
        endcase
    end

    assign beat    = (state_q == XFER) && udp_tvalid_out && udp_tready_in;
    assign cnt_inc = {1'b0, byte_cnt_q} + 17'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            rr_ptr_q      <= IW'(NUM_REQ - 1);
            byte_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            port_q        <= '0;
            len_q         <= '0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        grant_q          <= '0;
                        grant_q[win_idx] <= 1'b1;
                        gidx_q           <= win_idx;
                        rr_ptr_q         <= win_idx;
                        port_q           <= req_dest_port_in[16*32'(win_idx) +: 16];
                        len_q            <= req_length_in[16*32'(win_idx) +: 16];
                        byte_cnt_q       <= '0;
                        stall_cnt_q      <= '0;
                        state_q          <= XFER;
                    end
                end
                XFER: begin
                    // An accepted beat always beats the watchdog, so a tlast at expiry closes cleanly.
                    if (beat) begin
                        stall_cnt_q <= '0;
                        if (byte_cnt_q != 16'hFFFF) begin
                            byte_cnt_q <= byte_cnt_q + 16'd1;
                        end
                        if (udp_tlast_out) begin
                            len_err_q <= (cnt_inc != {1'b0, len_q});
                            grant_q   <= '0;
                            state_q   <= IDLE;
                        end
                    end else if (stall_cnt_q == SW'(TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ABORT;
                    end else begin
                        stall_cnt_q <= stall_cnt_q + SW'(1);
                    end
                end
                ABORT: begin
                    if (udp_tready_in) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_out         = grant_q;
    assign busy_out          = (state_q != IDLE);
    assign udp_dest_port_out = port_q;
    assign udp_length_out    = len_q;
    assign len_err_out       = len_err_q;
    assign timeout_err_out   = timeout_err_q;

endmodule

// File: tb/tb_udp_tx_arb.sv
// tb_udp_tx_arb: directed and randomized packet traffic for udp_tx_arb, checked against a
// transaction-level round-robin model of expected packet order, contents and error pulses.
module tb_udp_tx_arb;

    localparam int unsigned NR  = 2;
    localparam int unsigned TMO = 16;

    typedef struct {
        logic [63:0] data;
        int unsigned beats;
        logic [15:0] port;
        logic [15:0] len;
    } pkt_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [8*NR-1:0] req_tdata_in = '0;
    logic [NR-1:0]   req_tvalid_in = '0;
    logic [NR-1:0]   req_tlast_in = '0;
    logic [NR-1:0]   req_tready_out;
    logic [16*NR-1:0] req_dest_port_in = '0;
    logic [16*NR-1:0] req_length_in = '0;
    logic [7:0]      udp_tdata_out;
    logic            udp_tvalid_out;
    logic            udp_tlast_out;
    logic            udp_tready_in = 1'b0;
    logic [15:0]     udp_dest_port_out;
    logic [15:0]     udp_length_out;
    logic [NR-1:0]   grant_out;
    logic            busy_out;
    logic            len_err_out;
    logic            timeout_err_out;

    udp_tx_arb #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_tdata_in      (req_tdata_in),
        .req_tvalid_in     (req_tvalid_in),
        .req_tlast_in      (req_tlast_in),
        .req_tready_out    (req_tready_out),
        .req_dest_port_in  (req_dest_port_in),
        .req_length_in     (req_length_in),
        .udp_tdata_out     (udp_tdata_out),
        .udp_tvalid_out    (udp_tvalid_out),
        .udp_tlast_out     (udp_tlast_out),
        .udp_tready_in     (udp_tready_in),
        .udp_dest_port_out (udp_dest_port_out),
        .udp_length_out    (udp_length_out),
        .grant_out         (grant_out),
        .busy_out          (busy_out),
        .len_err_out       (len_err_out),
        .timeout_err_out   (timeout_err_out)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    int unsigned n_total = 0;

    pkt_t        pq [NR][$];
    int unsigned bi [NR];
    logic        acc [NR];
    pkt_t        exp_q[$];
    int unsigned exp_id[$];
    int unsigned obs_ids[$];
    int unsigned mptr = NR - 1;
    int unsigned ob = 0;
    logic        err_pend = 1'b0;
    int unsigned rmode = 0;
    int unsigned low_run = 0;
    int unsigned n_beats = 0;
    int unsigned n_lerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic pkt_t mk(input logic [63:0] d, input int unsigned b,
                                input logic [15:0] port, input logic [15:0] len);
        pkt_t p;
        p.data  = d;
        p.beats = b;
        p.port  = port;
        p.len   = len;
        return p;
    endfunction

    function automatic pkt_t rnd_pkt();
        int unsigned b;
        b = $urandom_range(1, 8);
        return mk({$urandom, $urandom}, b, 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 9)) : 16'(b));
    endfunction

    // Expected packet order: each grant goes to the first requester with work left,
    // scanning upward (wrapping) from the one just past the previous winner.
    task automatic build_expect();
        int unsigned rem [NR];
        int unsigned taken [NR];
        int unsigned c;
        int unsigned left;
        left = 0;
        for (int i = 0; i < NR; i++) begin
            rem[i]   = pq[i].size();
            taken[i] = 0;
            left += rem[i];
        end
        while (left > 0) begin
            c = 0;
            for (int unsigned k = 1; k <= NR; k++) begin
                c = (mptr + k) % NR;
                if (rem[c] > 0) break;
            end
            exp_q.push_back(pq[c][taken[c]]);
            exp_id.push_back(c);
            taken[c]++;
            rem[c]--;
            left--;
            mptr = c;
        end
    endtask

    task automatic drive_inputs();
        pkt_t p;
        for (int i = 0; i < NR; i++) begin
            if (pq[i].size() > 0) begin
                p = pq[i][0];
                req_tvalid_in[i]           = 1'b1;
                req_tdata_in[8*i +: 8]     = p.data[8*bi[i] +: 8];
                req_tlast_in[i]            = (bi[i] + 1 == p.beats);
                req_dest_port_in[16*i +: 16] = p.port;
                req_length_in[16*i +: 16]    = p.len;
            end else begin
                req_tvalid_in[i] = 1'b0;
                req_tlast_in[i]  = 1'b0;
            end
        end
        case (rmode)
            0: udp_tready_in = 1'b1;
            1: udp_tready_in = ~udp_tready_in;
            default: begin
                if (low_run >= 3) udp_tready_in = 1'b1;
                else udp_tready_in = ($urandom_range(0, 2) != 0);
                low_run = udp_tready_in ? 0 : low_run + 1;
            end
        endcase
    endtask

    task automatic monitor();
        pkt_t p;
        int unsigned gid;
        for (int i = 0; i < NR; i++) acc[i] = req_tvalid_in[i] & req_tready_out[i];
        chk("ready_only_granted", req_tready_out & ~grant_out, 64'd0);
        chk("grant_onehot0", $onehot0(grant_out), 64'd1);
        chk("len_err", len_err_out, err_pend);
        if (len_err_out) n_lerr++;
        err_pend = 1'b0;
        chk("timeout_err_quiet", timeout_err_out, 64'd0);
        if (udp_tvalid_out && udp_tready_in) begin
            n_beats++;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", udp_tvalid_out, 64'd0);
            end else begin
                p = exp_q[0];
                chk("beat_grant", grant_out, 64'd1 << exp_id[0]);
                chk("beat_data", udp_tdata_out, p.data[8*ob +: 8]);
                chk("beat_last", udp_tlast_out, ob + 1 == p.beats);
                if (ob == 0) begin
                    chk("pkt_port", udp_dest_port_out, p.port);
                    chk("pkt_len", udp_length_out, p.len);
                end
                if (ob + 1 >= p.beats) begin
                    gid = 0;
                    for (int j = 0; j < NR; j++) if (grant_out[j]) gid = j;
                    obs_ids.push_back(gid);
                    err_pend = (p.beats != 32'(p.len));
                    void'(exp_q.pop_front());
                    void'(exp_id.pop_front());
                    ob = 0;
                end else begin
                    ob++;
                end
            end
        end
    endtask

    task automatic advance();
        pkt_t p;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && pq[i].size() > 0) begin
                p = pq[i][0];
                if (bi[i] + 1 >= p.beats) begin
                    void'(pq[i].pop_front());
                    bi[i] = 0;
                end else begin
                    bi[i]++;
                end
            end
        end
    endtask

    task automatic engine_cycle();
        drive_inputs();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic run_engine(input int unsigned bound);
        int unsigned cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < bound) begin
            engine_cycle();
            cyc++;
        end
        chk("engine_drained", exp_q.size(), 64'd0);
        engine_cycle();
        exp_q.delete();
        exp_id.delete();
        for (int i = 0; i < NR; i++) begin
            pq[i].delete();
            bi[i] = 0;
        end
        ob = 0;
        err_pend = 1'b0;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        req_tvalid_in = '0;
        req_tlast_in  = '0;
        udp_tready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant_out, 64'd0);
        chk("rst_busy", busy_out, 64'd0);
        chk("rst_stream", {udp_tvalid_out, udp_tlast_out, udp_tdata_out}, 64'd0);
        chk("rst_port_len", {udp_dest_port_out, udp_length_out}, 64'd0);
        chk("rst_errs", {len_err_out, timeout_err_out}, 64'd0);
        chk("rst_ready", req_tready_out, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mptr = NR - 1;
    endtask

    initial begin
        #500000;
        $display("FAIL tb_watchdog: observed no finish, expected finish");
        $fatal(1, "simulation did not terminate");
    end

    initial begin
        logic [5:0] ord;
        for (int i = 0; i < NR; i++) bi[i] = 0;

        do_reset();

        // T2: both requesters continuously valid, three packets each
        rmode = 0;
        for (int n = 0; n < 3; n++) begin
            pq[0].push_back(mk({$urandom, $urandom}, 2 + n, 16'h0100 + 16'(n), 16'(2 + n)));
            pq[1].push_back(mk({$urandom, $urandom}, 3, 16'h0200 + 16'(n), 16'd3));
        end
        obs_ids.delete();
        build_expect();
        run_engine(300);
        chk("t2_count", obs_ids.size(), 64'd6);
        ord = '0;
        for (int k = 0; k < 6 && k < obs_ids.size(); k++) ord[k] = obs_ids[k][0];
        chk("t2_order", ord, 64'b101010);

        // T1: single 4-beat packet, grant one cycle after tvalid
        rmode = 0;
        pq[0].push_back(mk(64'h00000000A3A2A1A0, 4, 16'h1F90, 16'd4));
        build_expect();
        drive_inputs();
        @(negedge clk);
        chk("t1_pre_grant", grant_out, 64'd0);
        chk("t1_pre_stream", udp_tvalid_out, 64'd0);
        chk("t1_pre_ready", req_tready_out, 64'd0);
        @(posedge clk);
        #1;
        chk("t1_grant", grant_out, 64'd1);
        n_lerr = 0;
        run_engine(100);
        chk("t1_port_held", udp_dest_port_out, 64'h1F90);
        chk("t1_idle", {busy_out, grant_out}, 64'd0);
        chk("t1_no_err", n_lerr, 64'd0);

        // T3: ready toggling 1010 during an 8-byte packet
        rmode = 1;
        udp_tready_in = 1'b0;
        n_beats = 0;
        pq[0].push_back(mk(64'h8877665544332211, 8, 16'h0303, 16'd8));
        build_expect();
        run_engine(100);
        chk("t3_beats", n_beats, 64'd8);

        // T4: short packet against declared length, then normal, then length 0
        rmode = 0;
        n_lerr = 0;
        pq[0].push_back(mk(64'h0000000000C3C2C1, 3, 16'h0404, 16'd5));
        pq[0].push_back(mk(64'h000000000000D2D1, 2, 16'h0405, 16'd2));
        pq[0].push_back(mk(64'h00000000000000E1, 1, 16'h0406, 16'd0));
        build_expect();
        run_engine(100);
        chk("t4_pulses", n_lerr, 64'd2);

        // T5: req0 stalls after two beats; watchdog closes the packet, then req1 runs
        udp_tready_in = 1'b1;
        req_tvalid_in[0] = 1'b1;
        req_tdata_in[7:0] = 8'h11;
        req_tlast_in[0] = 1'b0;
        req_dest_port_in[15:0] = 16'h0505;
        req_length_in[15:0] = 16'd2;
        @(posedge clk);
        #1;
        chk("t5_grant0", grant_out, 64'd1);
        req_tvalid_in[1] = 1'b1;
        req_tdata_in[15:8] = 8'h55;
        req_tlast_in[1] = 1'b1;
        req_dest_port_in[31:16] = 16'h2222;
        req_length_in[31:16] = 16'd1;
        @(posedge clk);
        #1;
        req_tdata_in[7:0] = 8'h22;
        @(posedge clk);
        #1;
        req_tvalid_in[0] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("t5_stall_stream", udp_tvalid_out, 64'd0);
            chk("t5_stall_tmo", timeout_err_out, 64'd0);
            chk("t5_stall_grant", grant_out, 64'd1);
            chk("t5_stall_rdy1", req_tready_out[1], 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("t5_tmo_pulse", timeout_err_out, 64'd1);
        chk("t5_abort_beat", {udp_tvalid_out, udp_tlast_out, udp_tdata_out}, 64'h300);
        chk("t5_abort_ready", req_tready_out, 64'd0);
        chk("t5_abort_busy", busy_out, 64'd1);
        @(posedge clk);
        #1;
        chk("t5_idle_grant", grant_out, 64'd0);
        chk("t5_tmo_single", timeout_err_out, 64'd0);
        @(posedge clk);
        #1;
        chk("t5_grant1", grant_out, 64'd2);
        @(negedge clk);
        chk("t5_req1_beat", {udp_tvalid_out, udp_tlast_out, udp_tdata_out}, 64'h355);
        @(posedge clk);
        #1;
        req_tvalid_in[1] = 1'b0;
        req_tlast_in[1] = 1'b0;
        @(negedge clk);
        chk("t5_req1_lenok", len_err_out, 64'd0);
        chk("t5_done", grant_out, 64'd0);
        @(posedge clk);
        #1;
        mptr = 1;

        // Randomized traffic under random downstream backpressure
        rmode = 2;
        low_run = 0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NR; i++) begin
                int unsigned np;
                np = $urandom_range(0, 4) + ((i == 0) ? 1 : 0);
                for (int j = 0; j < np; j++) pq[i].push_back(rnd_pkt());
            end
            build_expect();
            run_engine(2000);
        end

        // T6: asynchronous reset in the middle of a packet
        rmode = 0;
        udp_tready_in = 1'b1;
        req_tvalid_in[0] = 1'b1;
        req_tdata_in[7:0] = 8'h31;
        req_tlast_in[0] = 1'b0;
        req_dest_port_in[15:0] = 16'h0606;
        req_length_in[15:0] = 16'd6;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        req_tdata_in[7:0] = 8'h32;
        @(posedge clk);
        #1;
        req_tdata_in[7:0] = 8'h33;
        #1;
        chk("t6_pre_busy", busy_out, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_stream", {udp_tvalid_out, udp_tlast_out, udp_tdata_out}, 64'd0);
        chk("t6_rst_grant", {busy_out, grant_out}, 64'd0);
        chk("t6_rst_ready", req_tready_out, 64'd0);
        chk("t6_rst_port", udp_dest_port_out, 64'd0);
        req_tdata_in = 16'h4241;
        req_tlast_in = 2'b11;
        req_tvalid_in = 2'b11;
        req_length_in = {16'd1, 16'd1};
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_first_grant", grant_out, 64'd1);
        @(negedge clk);
        chk("t6_beat", {udp_tvalid_out, udp_tlast_out, udp_tdata_out}, 64'h341);
        @(posedge clk);
        #1;
        req_tvalid_in[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_next_grant", grant_out, 64'd2);
        req_tvalid_in = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
